cim_mem_req_arbiter: RTL

- Initiator-side front end for one single-port CIM memory (int_res or params). Sits between the CIM FSMs/datapath units and the memory port.
- Accepts valid/ready read and write requests from N_SRC sources and issues at most one one-hot access per cycle as registered MemAccessSignals fields.
- Routes returned read data back to the originating source with a valid strobe.
- Fixed priority (index 0 highest, matching source enum order), plus an aging promotion so low-priority sources cannot starve.

---
 rtl/cim_mem_req_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cim_mem_req_arbiter.sv
// Fixed-priority arbiter with aging promotion in front of one single-port CIM memory.
// Issues a registered one-hot access one cycle after accept; read data returns two cycles after accept.
module cim_mem_req_arbiter #(
  parameter int               N_SRC         = 6,
  parameter int               ADDR_W        = 10,
  parameter int               DATA_W        = 16,
  parameter int               MAX_WAIT      = 8,
  parameter logic [N_SRC-1:0] NO_WRITE_MASK = 6'b000100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          i_req_valid,
  input  logic [N_SRC-1:0]          i_req_write,
  input  logic [N_SRC*ADDR_W-1:0]   i_req_addr,
  input  logic [N_SRC*DATA_W-1:0]   i_req_wdata,
  output logic [N_SRC-1:0]          o_req_ready,
  output logic [N_SRC-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic [N_SRC-1:0]          o_mem_read_req_src,
  output logic [N_SRC-1:0]          o_mem_write_req_src,
  output logic [N_SRC*ADDR_W-1:0]   o_mem_addr_table,
  output logic [N_SRC*DATA_W-1:0]   o_mem_write_data,
  input  logic [DATA_W-1:0]         i_mem_read_data,
  output logic                      o_err_illegal_write
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [CNT_W-1:0]        r_wait_cnt [N_SRC];
  logic [N_SRC-1:0]        r_mem_rd;
  logic [N_SRC-1:0]        r_mem_wr;
  logic [N_SRC*ADDR_W-1:0] r_addr_tbl;
  logic [N_SRC*DATA_W-1:0] r_wdata_tbl;
  logic                    r_err;
  logic [N_SRC-1:0]        r_rsp_vld;
  logic [DATA_W-1:0]       r_rsp_hold;

  logic [N_SRC-1:0]  w_urgent;
  logic [N_SRC-1:0]  w_pick;
  logic [N_SRC-1:0]  w_grant_oh;
  logic [N_SRC-1:0]  w_hs;
  logic [IDX_W-1:0]  w_grant_idx;
  logic              w_found;
  logic              w_acc;
  logic              w_acc_write;
  logic              w_illegal;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;

  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_urgent[i] = i_req_valid[i] && (r_wait_cnt[i] == CNT_W'(MAX_WAIT));
    end
  end

  // Any urgent source pre-empts the plain priority order.
  assign w_pick = (|w_urgent) ? w_urgent : i_req_valid;

  always_comb begin
    w_grant_oh  = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_pick[i] && !w_found) begin
        w_grant_oh[i] = 1'b1;
        w_grant_idx   = IDX_W'(i);
        w_found       = 1'b1;
      end
    end
  end

  assign o_req_ready = rst_n ? w_grant_oh : '0;
  assign w_hs        = i_req_valid & o_req_ready;
  assign w_acc       = |w_hs;
  assign w_acc_write = i_req_write[w_grant_idx];
  assign w_illegal   = w_acc && w_acc_write && NO_WRITE_MASK[w_grant_idx];
  assign w_acc_addr  = i_req_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_acc_wdata = i_req_wdata[w_grant_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) r_wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!i_req_valid[i] || w_hs[i]) begin
          r_wait_cnt[i] <= '0;
        end else if (r_wait_cnt[i] != CNT_W'(MAX_WAIT)) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Every slot is rewritten each cycle so idle cycles present an all-zero access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rd    <= '0;
      r_mem_wr    <= '0;
      r_addr_tbl  <= '0;
      r_wdata_tbl <= '0;
      r_err       <= 1'b0;
    end else begin
      r_mem_rd    <= '0;
      r_mem_wr    <= '0;
      r_addr_tbl  <= '0;
      r_wdata_tbl <= '0;
      r_err       <= w_illegal;
      if (w_acc && !w_illegal) begin
        r_addr_tbl[w_grant_idx*ADDR_W +: ADDR_W] <= w_acc_addr;
        if (w_acc_write) begin
          r_mem_wr[w_grant_idx]                     <= 1'b1;
          r_wdata_tbl[w_grant_idx*DATA_W +: DATA_W] <= w_acc_wdata;
        end else begin
          r_mem_rd[w_grant_idx] <= 1'b1;
        end
      end
    end
  end

  // The issued read vector doubles as the return tag; memory data lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld  <= '0;
      r_rsp_hold <= '0;
    end else begin
      r_rsp_vld <= r_mem_rd;
      if (|r_rsp_vld) r_rsp_hold <= i_mem_read_data;
    end
  end

  assign o_rsp_valid         = r_rsp_vld;
  assign o_rsp_data          = (|r_rsp_vld) ? i_mem_read_data : r_rsp_hold;
  assign o_mem_read_req_src  = r_mem_rd;
  assign o_mem_write_req_src = r_mem_wr;
  assign o_mem_addr_table    = r_addr_tbl;
  assign o_mem_write_data    = r_wdata_tbl;
  assign o_err_illegal_write = r_err;

  a_one_access: assert property (@(posedge clk) disable iff (!rst_n)
    $countones({o_mem_read_req_src, o_mem_write_req_src}) <= 1);
  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(o_req_ready) <= 1);
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(o_rsp_valid));

endmodule
